// File: rtl/vblank_update_scheduler.sv
// Paces game-state updates to vertical blanking: samples the VGA line counter, divides frames
// into game ticks and runs a req/ack handshake with overrun detection, pause and single-step.
module vblank_update_scheduler #(
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DIV_W    = 4,
  parameter int unsigned FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        vOut,
  input  logic [DIV_W-1:0]  speed,
  input  logic              pause,
  input  logic              step,
  input  logic              upd_ack,
  output logic              upd_req,
  output logic              in_vblank,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [9:0] VActive = 10'(V_ACTIVE);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic [9:0]          v_s1_q, v_s2_q, v_cur_q, v_cur_d;
  logic                frame_start_q, frame_start_d;
  logic                vblank_end_q, vblank_end_d;
  logic                in_vblank_q, in_vblank_d;
  logic                upd_req_q, upd_req_d;
  logic                overrun_q, overrun_d;
  logic                step_pend_q, step_pend_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                launch;
  logic                overrun_set;

  always_comb begin
    // Only accept a new line value once two samples agree, so bus skew never reaches v_cur.
    v_cur_d       = (v_s1_q == v_s2_q) ? v_s2_q : v_cur_q;
    frame_start_d = (v_cur_d == VActive) && (v_cur_q != VActive);
    vblank_end_d  = (v_cur_d == '0) && (v_cur_q != '0);
    in_vblank_d   = (v_cur_d >= VActive);

    launch      = 1'b0;
    div_cnt_d   = div_cnt_q;
    step_pend_d = step_pend_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start_q) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      if (pause) begin
        if (step_pend_q) begin
          launch      = 1'b1;
          step_pend_d = 1'b0;
          div_cnt_d   = '0;
        end
      end else if (div_cnt_q >= speed) begin
        launch    = 1'b1;
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
    if (pause && step) step_pend_d = 1'b1;

    state_d     = state_q;
    overrun_set = 1'b0;
    unique case (state_q)
      StIdle: if (launch) state_d = StReq;
      StReq: begin
        if (upd_ack) begin
          state_d = StIdle;
        end else if (vblank_end_q || (frame_start_q && launch)) begin
          overrun_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    upd_req_d = (state_d == StReq);

    if (overrun_set)      overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      v_s1_q        <= '0;
      v_s2_q        <= '0;
      v_cur_q       <= '0;
      frame_start_q <= 1'b0;
      vblank_end_q  <= 1'b0;
      in_vblank_q   <= 1'b0;
      upd_req_q     <= 1'b0;
      overrun_q     <= 1'b0;
      step_pend_q   <= 1'b0;
      div_cnt_q     <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      v_s1_q        <= vOut;
      v_s2_q        <= v_s1_q;
      v_cur_q       <= v_cur_d;
      frame_start_q <= frame_start_d;
      vblank_end_q  <= vblank_end_d;
      in_vblank_q   <= in_vblank_d;
      upd_req_q     <= upd_req_d;
      overrun_q     <= overrun_d;
      step_pend_q   <= step_pend_d;
      div_cnt_q     <= div_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign upd_req   = upd_req_q;
  assign in_vblank = in_vblank_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler: raster sweeps, divider, glitches, overrun,
// pause/step and asynchronous reset during a request.
module tb_vblank_update_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  vOut = '0;
  logic [3:0]  speed = '0;
  logic        pause = 1'b0;
  logic        step = 1'b0;
  logic        upd_ack = 1'b0;
  logic        upd_req;
  logic        in_vblank;
  logic        overrun;
  logic        overrun_clr = 1'b0;
  logic [15:0] frame_cnt;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int req_cnt = 0;
  int rise_cyc = 0;
  int c480 = 0;
  logic [15:0] rise_fc[$];
  logic req_prev = 1'b0;
  bit ack_en = 1'b0;

  vblank_update_scheduler #(
    .V_ACTIVE(480),
    .DIV_W   (4),
    .FCNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vOut       (vOut),
    .speed      (speed),
    .pause      (pause),
    .step       (step),
    .upd_ack    (upd_ack),
    .upd_req    (upd_req),
    .in_vblank  (in_vblank),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Request monitor: counts rising edges of upd_req and records frame_cnt at each.
  initial forever begin
    @(negedge clk);
    if (upd_req && !req_prev) begin
      req_cnt++;
      rise_cyc = cyc;
      rise_fc.push_back(frame_cnt);
    end
    req_prev = upd_req;
  end

  // Game-logic model: acknowledges 5 clk after seeing a request.
  initial forever begin
    @(negedge clk);
    if (ack_en && upd_req) begin
      repeat (4) @(negedge clk);
      upd_ack = 1'b1;
      @(negedge clk);
      upd_ack = 1'b0;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_v(input logic [9:0] v, input int n);
    vOut = v;
    if (v == 10'd480) c480 = cyc;
    hold(n);
  endtask

  task automatic frame_short(input bit do_step);
    vOut = 10'd200;
    hold(5);
    if (do_step) begin
      step = 1'b1; hold(1); step = 1'b0; hold(3);
      step = 1'b1; hold(1); step = 1'b0;
    end
    hold(10);
    set_v(10'd479, 20);
    set_v(10'd480, 20);
    set_v(10'd520, 20);
    set_v(10'd0, 20);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    vOut = '0; speed = '0; pause = 1'b0; step = 1'b0; overrun_clr = 1'b0;
    hold(3);
    rst = 1'b0;
    hold(2);
    req_cnt = 0;
    rise_fc.delete();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    hold(3);
    n_assert++; if (upd_req !== 1'b0) begin n_fail++; $display("FAIL reset_upd_req: got %b expected 0", upd_req); end
    n_assert++; if (in_vblank !== 1'b0) begin n_fail++; $display("FAIL reset_in_vblank: got %b expected 0", in_vblank); end
    n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_assert++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    rst = 1'b0;
    hold(2);
  endtask

  task automatic test_sweep();
    apply_reset();
    ack_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v < 525; v++) set_v(10'(v), 16);
      n_assert++; if (req_cnt !== f + 1) begin n_fail++; $display("FAIL sweep_req_cnt: got %0d expected %0d", req_cnt, f + 1); end
      n_assert++; if (rise_cyc - c480 !== 4) begin n_fail++; $display("FAIL sweep_latency: got %0d expected 4", rise_cyc - c480); end
    end
    n_assert++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL sweep_frame_cnt: got %0d expected 2", frame_cnt); end
    n_assert++; if (in_vblank !== 1'b1) begin n_fail++; $display("FAIL sweep_in_vblank_hi: got %b expected 1", in_vblank); end
    n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL sweep_overrun: got %b expected 0", overrun); end
    set_v(10'd0, 10);
    n_assert++; if (in_vblank !== 1'b0) begin n_fail++; $display("FAIL sweep_in_vblank_lo: got %b expected 0", in_vblank); end
  endtask

  task automatic test_divider();
    apply_reset();
    ack_en = 1'b1;
    speed = 4'd2;
    for (int f = 0; f < 9; f++) frame_short(1'b0);
    n_assert++; if (req_cnt !== 3) begin n_fail++; $display("FAIL div_req_cnt: got %0d expected 3", req_cnt); end
    for (int i = 0; i < 3; i++) begin
      if (i < rise_fc.size()) begin
        n_assert++;
        if (rise_fc[i] !== 16'(3 * (i + 1))) begin
          n_fail++; $display("FAIL div_req_frame%0d: got %0d expected %0d", i, rise_fc[i], 3 * (i + 1));
        end
      end
    end
    n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL div_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_glitch();
    apply_reset();
    ack_en = 1'b1;
    set_v(10'd479, 20);
    vOut = 10'h3FF;
    hold(1);
    set_v(10'd480, 20);
    set_v(10'd520, 20);
    n_assert++; if (req_cnt !== 1) begin n_fail++; $display("FAIL glitch_req_cnt: got %0d expected 1", req_cnt); end
    n_assert++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL glitch_frame_cnt: got %0d expected 1", frame_cnt); end
    n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL glitch_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_overrun();
    apply_reset();
    ack_en = 1'b0;
    set_v(10'd479, 20);
    set_v(10'd480, 20);
    set_v(10'd520, 20);
    set_v(10'd0, 20);
    n_assert++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    n_assert++; if (upd_req !== 1'b1) begin n_fail++; $display("FAIL ovr_req_held: got %b expected 1", upd_req); end
    upd_ack = 1'b1; hold(1); upd_ack = 1'b0;
    n_assert++; if (upd_req !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_drop: got %b expected 0", upd_req); end
    n_assert++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    overrun_clr = 1'b1; hold(1); overrun_clr = 1'b0;
    n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b expected 0", overrun); end
    // Clear lands on the same edge as the vblank_end-driven set.
    set_v(10'd479, 20);
    set_v(10'd480, 20);
    set_v(10'd520, 20);
    vOut = 10'd0;
    hold(3);
    overrun_clr = 1'b1; hold(1); overrun_clr = 1'b0;
    n_assert++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_beats_clr: got %b expected 1", overrun); end
    hold(10);
    upd_ack = 1'b1; hold(1); upd_ack = 1'b0;
    overrun_clr = 1'b1; hold(1); overrun_clr = 1'b0;
    // Ack lands on the same edge as vblank_end.
    set_v(10'd479, 20);
    set_v(10'd480, 20);
    set_v(10'd520, 20);
    vOut = 10'd0;
    hold(3);
    upd_ack = 1'b1; hold(1); upd_ack = 1'b0;
    hold(2);
    n_assert++; if (upd_req !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_wins_req: got %b expected 0", upd_req); end
    n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_wins: got %b expected 0", overrun); end
  endtask

  task automatic test_pause_step();
    apply_reset();
    ack_en = 1'b1;
    speed = 4'd3;
    for (int f = 0; f < 2; f++) frame_short(1'b0);
    pause = 1'b1;
    for (int f = 0; f < 4; f++) frame_short(1'b0);
    n_assert++; if (req_cnt !== 0) begin n_fail++; $display("FAIL pause_no_req: got %0d expected 0", req_cnt); end
    frame_short(1'b1);
    n_assert++; if (req_cnt !== 1) begin n_fail++; $display("FAIL step_one_req: got %0d expected 1", req_cnt); end
    pause = 1'b0;
    speed = 4'd1;
    frame_short(1'b1);
    n_assert++; if (req_cnt !== 1) begin n_fail++; $display("FAIL step_div_reset: got %0d expected 1", req_cnt); end
    frame_short(1'b0);
    n_assert++; if (req_cnt !== 2) begin n_fail++; $display("FAIL step_div_fire: got %0d expected 2", req_cnt); end
    pause = 1'b1;
    frame_short(1'b0);
    n_assert++; if (req_cnt !== 2) begin n_fail++; $display("FAIL step_unpaused_ignored: got %0d expected 2", req_cnt); end
    pause = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    apply_reset();
    ack_en = 1'b0;
    set_v(10'd479, 20);
    set_v(10'd480, 20);
    set_v(10'd0, 20);
    n_assert++; if (upd_req !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL rstreq_setup: got req=%b ovr=%b expected 1 1", upd_req, overrun); end
    rst = 1'b1;
    #1;
    n_assert++; if (upd_req !== 1'b0) begin n_fail++; $display("FAIL rstreq_upd_req: got %b expected 0", upd_req); end
    n_assert++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstreq_overrun: got %b expected 0", overrun); end
    n_assert++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rstreq_frame_cnt: got %0d expected 0", frame_cnt); end
    vOut = 10'd0;
    hold(3);
    rst = 1'b0;
    hold(2);
    req_cnt = 0;
    ack_en = 1'b1;
    set_v(10'd100, 20);
    set_v(10'd479, 20);
    set_v(10'd480, 20);
    n_assert++; if (req_cnt !== 1) begin n_fail++; $display("FAIL rstreq_after_req: got %0d expected 1", req_cnt); end
    n_assert++; if (rise_cyc - c480 !== 4) begin n_fail++; $display("FAIL rstreq_latency: got %0d expected 4", rise_cyc - c480); end
    n_assert++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rstreq_frame: got %0d expected 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_divider();
    test_glitch();
    test_overrun();
    test_pause_step();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
